huffman_gen: RTL and testbench

//  Parametrised successor of the fixed 6-symbol Huffman encoder. Builds a histogram

---
 rtl/huffman_gen.sv | 266 ++++++++++++++++++++++++++
 tb/tb_huffman_gen.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/huffman_gen.sv
// huffman_gen: frame histogram over NSAMP gray-level samples, followed by a
// sequential Huffman code build (one node visited per SCAN cycle, one merge
// per MERGE cycle). Repeats frame after frame.
//
// Handshake: a sample transfers on a rising clk edge where
// gray_valid && gray_ready. gray_ready depends only on the state, never on
// gray_valid, and is high only while counting.
module huffman_gen #(
  parameter int NSYM  = 6,
  parameter int DW    = 8,
  parameter int NSAMP = 100,
  parameter int CW    = 8,
  parameter int HW    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 gray_valid,
  input  logic [DW-1:0]        gray_data,
  output logic                 gray_ready,
  output logic                 CNT_valid,
  output logic [NSYM*CW-1:0]   CNT,
  output logic                 code_valid,
  output logic [NSYM*HW-1:0]   HC,
  output logic [NSYM*HW-1:0]   M,
  output logic [2:0]           state_dbg
);

  localparam int WW = CW + 1;          // node weight width
  localparam int LW = 4;               // code length / alive count width
  localparam int IW = $clog2(NSYM);    // node index width

  typedef enum logic [2:0] {
    S_COUNT  = 3'd0,
    S_REPORT = 3'd1,
    S_INIT   = 3'd2,
    S_SCAN   = 3'd3,
    S_MERGE  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t                     state_q, state_d;
  logic [CW-1:0]              sample_cnt_q, sample_cnt_d;
  logic [NSYM-1:0][CW-1:0]    cnt_q, cnt_d;
  logic [NSYM-1:0][WW-1:0]    w_q, w_d;
  logic [NSYM-1:0][NSYM-1:0]  set_q, set_d;
  logic [NSYM-1:0]            alive_q, alive_d;
  logic [NSYM-1:0][HW-1:0]    code_q, code_d;
  logic [NSYM-1:0][LW-1:0]    len_q, len_d;
  logic [LW-1:0]              alive_cnt_q, alive_cnt_d;
  logic [IW-1:0]              scan_idx_q, scan_idx_d;
  logic [IW-1:0]              a_idx_q, a_idx_d;
  logic [IW-1:0]              b_idx_q, b_idx_d;
  logic                       a_found_q, a_found_d;
  logic                       b_found_q, b_found_d;
  logic [NSYM-1:0][HW-1:0]    hc_q, hc_d;
  logic [NSYM-1:0][HW-1:0]    m_q, m_d;

  // operands picked out of the node arrays by the index registers
  logic [WW-1:0]              cand_w, a_w, b_w;
  logic [NSYM-1:0]            cand_s, a_s, b_s;
  logic                       cand_alive;
  logic [LW-1:0]              n_alive;

  // Lowest symbol index contained in a node's set (tie-break key).
  function automatic int low_idx(input logic [NSYM-1:0] s);
    int r;
    r = NSYM;
    for (int i = NSYM - 1; i >= 0; i--) begin
      if (s[i]) r = i;
    end
    return r;
  endfunction

  // Node x is "smaller" than node y: lower weight, ties broken by lower set index.
  function automatic logic node_less(input logic [WW-1:0] wx, input logic [NSYM-1:0] sx,
                                     input logic [WW-1:0] wy, input logic [NSYM-1:0] sy);
    return (wx < wy) || ((wx == wy) && (low_idx(sx) < low_idx(sy)));
  endfunction

  // Next-state, datapath and output decode.
  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    cnt_d        = cnt_q;
    w_d          = w_q;
    set_d        = set_q;
    alive_d      = alive_q;
    code_d       = code_q;
    len_d        = len_q;
    alive_cnt_d  = alive_cnt_q;
    scan_idx_d   = scan_idx_q;
    a_idx_d      = a_idx_q;
    b_idx_d      = b_idx_q;
    a_found_d    = a_found_q;
    b_found_d    = b_found_q;
    hc_d         = hc_q;
    m_d          = m_q;
    gray_ready   = 1'b0;
    CNT_valid    = 1'b0;
    code_valid   = 1'b0;
    n_alive      = '0;
    cand_w       = '0;
    cand_s       = '0;
    cand_alive   = 1'b0;
    a_w          = '0;
    a_s          = '0;
    b_w          = '0;
    b_s          = '0;

    for (int k = 0; k < NSYM; k++) begin
      if (scan_idx_q == IW'(k)) begin
        cand_w     = w_q[k];
        cand_s     = set_q[k];
        cand_alive = alive_q[k];
      end
      if (a_idx_q == IW'(k)) begin
        a_w = w_q[k];
        a_s = set_q[k];
      end
      if (b_idx_q == IW'(k)) begin
        b_w = w_q[k];
        b_s = set_q[k];
      end
    end

    case (state_q)
      S_COUNT: begin
        gray_ready = 1'b1;
        if (gray_valid) begin
          sample_cnt_d = sample_cnt_q + CW'(1);
          // values outside 1..NSYM count toward the frame but land in no bin
          for (int k = 0; k < NSYM; k++) begin
            if ((gray_data == DW'(k + 1)) && (cnt_q[k] != '1)) begin
              cnt_d[k] = cnt_q[k] + CW'(1);
            end
          end
          if (sample_cnt_q == CW'(NSAMP - 1)) state_d = S_REPORT;
        end
      end

      S_REPORT: begin
        CNT_valid = 1'b1;
        state_d   = S_INIT;
      end

      S_INIT: begin
        for (int k = 0; k < NSYM; k++) begin
          w_d[k]     = {1'b0, cnt_q[k]};
          set_d[k]   = NSYM'(1) << k;
          alive_d[k] = (cnt_q[k] != '0);
          n_alive    = n_alive + {{(LW-1){1'b0}}, (cnt_q[k] != '0)};
        end
        code_d      = '0;
        len_d       = '0;
        alive_cnt_d = n_alive;
        scan_idx_d  = '0;
        a_found_d   = 1'b0;
        b_found_d   = 1'b0;
        state_d     = (n_alive <= LW'(1)) ? S_DONE : S_SCAN;
      end

      S_SCAN: begin
        if (cand_alive) begin
          if (!a_found_q || node_less(cand_w, cand_s, a_w, a_s)) begin
            b_idx_d   = a_idx_q;
            b_found_d = a_found_q;
            a_idx_d   = scan_idx_q;
            a_found_d = 1'b1;
          end else if (!b_found_q || node_less(cand_w, cand_s, b_w, b_s)) begin
            b_idx_d   = scan_idx_q;
            b_found_d = 1'b1;
          end
        end
        scan_idx_d = scan_idx_q + IW'(1);
        if (scan_idx_q == IW'(NSYM - 1)) begin
          scan_idx_d = '0;
          state_d    = S_MERGE;
        end
      end

      S_MERGE: begin
        // code bits were cleared in INIT, so only the '1' side needs writing
        for (int s = 0; s < NSYM; s++) begin
          if (a_s[s]) code_d[s] = code_q[s] | (HW'(1) << len_q[s]);
          if (a_s[s] || b_s[s]) len_d[s] = len_q[s] + LW'(1);
        end
        for (int k = 0; k < NSYM; k++) begin
          if (a_idx_q == IW'(k)) begin
            w_d[k]   = a_w + b_w;
            set_d[k] = a_s | b_s;
          end
          if (b_idx_q == IW'(k)) alive_d[k] = 1'b0;
        end
        alive_cnt_d = alive_cnt_q - LW'(1);
        scan_idx_d  = '0;
        a_found_d   = 1'b0;
        b_found_d   = 1'b0;
        state_d     = (alive_cnt_q > LW'(2)) ? S_SCAN : S_DONE;
      end

      S_DONE: begin
        code_valid   = 1'b1;
        cnt_d        = '0;
        sample_cnt_d = '0;
        state_d      = S_COUNT;
      end

      default: state_d = S_COUNT;
    endcase

    // HC/M are captured on the edge into DONE so they are already valid while
    // code_valid is high; a lone alive symbol has length 0 but gets mask 1.
    if ((state_d == S_DONE) && (state_q != S_DONE)) begin
      for (int k = 0; k < NSYM; k++) begin
        hc_d[k] = code_d[k];
        if (len_d[k] == '0) m_d[k] = (cnt_q[k] != '0) ? HW'(1) : '0;
        else                m_d[k] = (HW'(1) << len_d[k]) - HW'(1);
      end
    end
  end

  // State and datapath registers; asynchronous reset discards all work.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_COUNT;
      sample_cnt_q <= '0;
      cnt_q        <= '0;
      w_q          <= '0;
      set_q        <= '0;
      alive_q      <= '0;
      code_q       <= '0;
      len_q        <= '0;
      alive_cnt_q  <= '0;
      scan_idx_q   <= '0;
      a_idx_q      <= '0;
      b_idx_q      <= '0;
      a_found_q    <= 1'b0;
      b_found_q    <= 1'b0;
      hc_q         <= '0;
      m_q          <= '0;
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      cnt_q        <= cnt_d;
      w_q          <= w_d;
      set_q        <= set_d;
      alive_q      <= alive_d;
      code_q       <= code_d;
      len_q        <= len_d;
      alive_cnt_q  <= alive_cnt_d;
      scan_idx_q   <= scan_idx_d;
      a_idx_q      <= a_idx_d;
      b_idx_q      <= b_idx_d;
      a_found_q    <= a_found_d;
      b_found_q    <= b_found_d;
      hc_q         <= hc_d;
      m_q          <= m_d;
    end
  end

  assign CNT       = cnt_q;
  assign HC        = hc_q;
  assign M         = m_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_huffman_gen.sv
// Bench for huffman_gen (NSYM=6, NSAMP=100): frames are driven sample by
// sample, expected histogram/code tables/latency are queued per frame and
// compared when CNT_valid and code_valid appear.
module tb_huffman_gen;

  localparam int NSYM  = 6;
  localparam int DW    = 8;
  localparam int NSAMP = 100;
  localparam int CW    = 8;
  localparam int HW    = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 gray_valid;
  logic [DW-1:0]        gray_data;
  logic                 gray_ready;
  logic                 CNT_valid;
  logic [NSYM*CW-1:0]   CNT;
  logic                 code_valid;
  logic [NSYM*HW-1:0]   HC;
  logic [NSYM*HW-1:0]   M;
  logic [2:0]           state_dbg;

  huffman_gen #(.NSYM(NSYM), .DW(DW), .NSAMP(NSAMP), .CW(CW), .HW(HW)) dut (
    .clk        (clk),
    .reset      (reset),
    .gray_valid (gray_valid),
    .gray_data  (gray_data),
    .gray_ready (gray_ready),
    .CNT_valid  (CNT_valid),
    .CNT        (CNT),
    .code_valid (code_valid),
    .HC         (HC),
    .M          (M),
    .state_dbg  (state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;

  int frame_buf[NSAMP];
  int lit_c[NSYM];
  int lit_h[NSYM];
  int lit_m[NSYM];

  logic [NSYM*CW-1:0] exp_cnt_q[$];
  logic [NSYM*HW-1:0] exp_hc_q[$];
  logic [NSYM*HW-1:0] exp_m_q[$];
  int                 exp_lat_q[$];

  logic [NSYM*HW-1:0] last_hc;
  logic [NSYM*HW-1:0] last_m;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic int low_of(input logic [NSYM-1:0] s);
    int r;
    r = NSYM;
    for (int i = NSYM - 1; i >= 0; i--) if (s[i]) r = i;
    return r;
  endfunction

  function automatic bit smaller(input int wx, input logic [NSYM-1:0] sx,
                                 input int wy, input logic [NSYM-1:0] sy);
    if (wx != wy) return wx < wy;
    return low_of(sx) < low_of(sy);
  endfunction

  // Build the Huffman table of frame_buf and push the expectation.
  task automatic push_model();
    int cnt[NSYM];
    int w[NSYM];
    logic [NSYM-1:0] st[NSYM];
    bit al[NSYM];
    int len[NSYM];
    int code[NSYM];
    int n, a, b, lat;
    logic [NSYM*CW-1:0] ecnt;
    logic [NSYM*HW-1:0] ehc, em;
    for (int k = 0; k < NSYM; k++) cnt[k] = 0;
    for (int i = 0; i < NSAMP; i++) begin
      if (frame_buf[i] >= 1 && frame_buf[i] <= NSYM && cnt[frame_buf[i]-1] < 255)
        cnt[frame_buf[i]-1]++;
    end
    n = 0;
    for (int k = 0; k < NSYM; k++) begin
      w[k] = cnt[k]; st[k] = '0; st[k][k] = 1'b1;
      al[k] = (cnt[k] != 0); len[k] = 0; code[k] = 0;
      if (al[k]) n++;
    end
    lat = 2 + (((n > 1) ? n : 1) - 1) * (NSYM + 1);
    while (n > 1) begin
      a = -1; b = -1;
      for (int k = 0; k < NSYM; k++) begin
        if (al[k]) begin
          if (a < 0 || smaller(w[k], st[k], w[a], st[a])) begin b = a; a = k; end
          else if (b < 0 || smaller(w[k], st[k], w[b], st[b])) b = k;
        end
      end
      for (int s = 0; s < NSYM; s++) begin
        if (st[a][s]) begin code[s] = code[s] | (1 << len[s]); len[s]++; end
        if (st[b][s]) len[s]++;
      end
      w[a] = w[a] + w[b];
      st[a] = st[a] | st[b];
      al[b] = 1'b0;
      n--;
    end
    for (int k = 0; k < NSYM; k++) begin
      ecnt[k*CW +: CW] = CW'(cnt[k]);
      ehc[k*HW +: HW]  = HW'(code[k]);
      if (len[k] == 0) em[k*HW +: HW] = (cnt[k] != 0) ? HW'(1) : HW'(0);
      else             em[k*HW +: HW] = HW'((1 << len[k]) - 1);
    end
    exp_cnt_q.push_back(ecnt);
    exp_hc_q.push_back(ehc);
    exp_m_q.push_back(em);
    exp_lat_q.push_back(lat);
  endtask

  // Push a literal expectation from lit_c/lit_h/lit_m.
  task automatic push_lit(input int lat);
    logic [NSYM*CW-1:0] ecnt;
    logic [NSYM*HW-1:0] ehc, em;
    for (int k = 0; k < NSYM; k++) begin
      ecnt[k*CW +: CW] = CW'(lit_c[k]);
      ehc[k*HW +: HW]  = HW'(lit_h[k]);
      em[k*HW +: HW]   = HW'(lit_m[k]);
    end
    exp_cnt_q.push_back(ecnt);
    exp_hc_q.push_back(ehc);
    exp_m_q.push_back(em);
    exp_lat_q.push_back(lat);
  endtask

  // ---------------- drivers ----------------
  task automatic drive_frame(input bit gaps, input bit hold_after);
    int wt;
    wt = 0;
    while (gray_ready !== 1'b1 && wt < 50) begin tick(); wt++; end
    n_tests++;
    if (wt >= 50) begin
      n_fail++;
      $display("FAIL ready_wait: gray_ready=%b after %0d cycles, required 1", gray_ready, wt);
    end
    for (int i = 0; i < NSAMP; i++) begin
      if (gaps && $urandom_range(3, 0) == 0) begin
        gray_valid = 1'b0;
        gray_data  = DW'($urandom_range(255, 0));
        tick();
      end
      gray_valid = 1'b1;
      gray_data  = DW'(frame_buf[i]);
      tick();
    end
    gray_valid = hold_after;
    gray_data  = DW'(1);
  endtask

  // Called right after the last accepting edge: DUT must be in REPORT.
  task automatic check_frame(input string name, input bit hold);
    logic [NSYM*CW-1:0] ecnt;
    logic [NSYM*HW-1:0] ehc, em;
    int elat, cyc;
    bit got;
    n_tests++;
    if (exp_cnt_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s_queue: expected queue empty, required an entry", name);
      return;
    end
    ecnt = exp_cnt_q.pop_front();
    ehc  = exp_hc_q.pop_front();
    em   = exp_m_q.pop_front();
    elat = exp_lat_q.pop_front();
    n_tests++;
    if (CNT_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_cnt_valid: got %b, required 1", name, CNT_valid);
    end
    n_tests++;
    if (CNT !== ecnt) begin
      n_fail++;
      $display("FAIL %s_cnt: got %h, required %h", name, CNT, ecnt);
    end
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 400) begin
      tick();
      cyc++;
      if (code_valid === 1'b1) got = 1'b1;
      else begin
        n_tests++;
        if (CNT !== ecnt || CNT_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL %s_build_cnt: cyc %0d CNT=%h CNT_valid=%b, required %h / 0",
                   name, cyc, CNT, CNT_valid, ecnt);
        end
        n_tests++;
        if (HC !== last_hc || M !== last_m) begin
          n_fail++;
          $display("FAIL %s_hold_hcm: cyc %0d HC=%h M=%h, required %h / %h",
                   name, cyc, HC, M, last_hc, last_m);
        end
      end
      if (hold) begin
        n_tests++;
        if (gray_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL %s_ready_low: cyc %0d gray_ready=%b, required 0", name, cyc, gray_ready);
        end
      end
    end
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s_code_valid_timeout: no code_valid in %0d cycles, required at %0d",
               name, cyc, elat);
    end else begin
      n_tests++;
      if (cyc != elat) begin
        n_fail++;
        $display("FAIL %s_latency: got %0d cycles, required %0d", name, cyc, elat);
      end
      n_tests++;
      if (HC !== ehc) begin
        n_fail++;
        $display("FAIL %s_hc: got %h, required %h", name, HC, ehc);
      end
      n_tests++;
      if (M !== em) begin
        n_fail++;
        $display("FAIL %s_m: got %h, required %h", name, M, em);
      end
    end
    last_hc = ehc;
    last_m  = em;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    gray_valid = 1'b0;
    gray_data = '0;
    tick();
    tick();
    n_tests++;
    if (CNT !== '0 || HC !== '0 || M !== '0) begin
      n_fail++;
      $display("FAIL reset_buses: CNT=%h HC=%h M=%h, required all 0", CNT, HC, M);
    end
    n_tests++;
    if (CNT_valid !== 1'b0 || code_valid !== 1'b0 || gray_ready !== 1'b1 || state_dbg !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: CNT_valid=%b code_valid=%b gray_ready=%b state=%0d, required 0 0 1 0",
               CNT_valid, code_valid, gray_ready, state_dbg);
    end
    reset = 1'b1;
    tick();
    last_hc = '0;
    last_m  = '0;
  endtask

  task automatic fill_basic();
    int idx, tmp, j;
    idx = 0;
    for (int i = 0; i < 30; i++) begin frame_buf[idx] = 1; idx++; end
    for (int i = 0; i < 10; i++) begin frame_buf[idx] = 2; idx++; end
    for (int i = 0; i < 20; i++) begin frame_buf[idx] = 3; idx++; end
    for (int i = 0; i < 15; i++) begin frame_buf[idx] = 4; idx++; end
    for (int i = 0; i < 25; i++) begin frame_buf[idx] = 5; idx++; end
    for (int i = 0; i < NSAMP; i++) begin
      j = int'($urandom_range(NSAMP - 1, 0));
      tmp = frame_buf[i]; frame_buf[i] = frame_buf[j]; frame_buf[j] = tmp;
    end
    lit_c = '{30, 10, 20, 15, 25, 0};
    lit_h = '{0, 5, 3, 4, 1, 0};
    lit_m = '{3, 7, 3, 7, 3, 0};
  endtask

  task automatic test_basic();
    fill_basic();
    push_lit(30);
    drive_frame(1'b1, 1'b0);
    check_frame("basic", 1'b0);
  endtask

  task automatic test_single_symbol();
    for (int i = 0; i < NSAMP; i++) frame_buf[i] = 3;
    lit_c = '{0, 0, 100, 0, 0, 0};
    lit_h = '{0, 0, 0, 0, 0, 0};
    lit_m = '{0, 0, 1, 0, 0, 0};
    push_lit(2);
    drive_frame(1'b1, 1'b0);
    check_frame("single", 1'b0);
  endtask

  task automatic test_out_of_range();
    int tbl[5];
    tbl = '{0, 7, 9, 200, 255};
    for (int i = 0; i < NSAMP; i++) frame_buf[i] = tbl[$urandom_range(4, 0)];
    lit_c = '{0, 0, 0, 0, 0, 0};
    lit_h = '{0, 0, 0, 0, 0, 0};
    lit_m = '{0, 0, 0, 0, 0, 0};
    push_lit(2);
    drive_frame(1'b0, 1'b0);
    check_frame("out_of_range", 1'b0);
  endtask

  task automatic test_hold_valid();
    fill_basic();
    push_lit(30);
    drive_frame(1'b0, 1'b1);
    check_frame("hold", 1'b1);
    // gray_valid stays high with data 1: that sample belongs to the next frame
    tick();
    n_tests++;
    if (gray_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_ready_after_done: gray_ready=%b, required 1", gray_ready);
    end
    frame_buf[0] = 1;
    for (int i = 1; i < NSAMP; i++) frame_buf[i] = int'($urandom_range(NSYM, 1));
    push_model();
    drive_frame(1'b0, 1'b0);
    check_frame("hold_next", 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    for (int i = 0; i < 50; i++) begin
      gray_valid = 1'b1;
      gray_data  = DW'(2);
      tick();
    end
    gray_valid = 1'b0;
    reset = 1'b0;
    #2;
    n_tests++;
    if (CNT !== '0 || HC !== '0 || M !== '0) begin
      n_fail++;
      $display("FAIL midreset_clear: CNT=%h HC=%h M=%h, required all 0", CNT, HC, M);
    end
    tick();
    reset = 1'b1;
    tick();
    last_hc = '0;
    last_m  = '0;
    for (int i = 0; i < NSAMP; i++) frame_buf[i] = int'($urandom_range(NSYM, 1));
    push_model();
    drive_frame(1'b1, 1'b0);
    check_frame("midreset_frame", 1'b0);
  endtask

  task automatic test_back_to_back();
    int tbl[4];
    for (int i = 0; i < NSAMP; i++) frame_buf[i] = int'($urandom_range(NSYM, 1));
    push_model();
    drive_frame(1'b0, 1'b0);
    check_frame("b2b_first", 1'b0);
    tbl = '{2, 5, 6, 0};
    for (int i = 0; i < NSAMP; i++) frame_buf[i] = tbl[$urandom_range(3, 0)];
    push_model();
    drive_frame(1'b0, 1'b0);
    check_frame("b2b_second", 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single_symbol();
    test_out_of_range();
    test_hold_valid();
    test_reset_mid_frame();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
